// File: rtl/touch_pio_pkg.sv
// Shared register offsets and edge-type encodings for the touch PIO.
package touch_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_SET      = 3'd4;
  localparam logic [2:0] ADDR_CLR      = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/touch_pio_sync_edge.sv
// Two-flop pad synchroniser with a previous-sample register and per-bit edge decode.
module touch_pio_sync_edge
  import touch_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EDGE_TYPE = EDGE_ANY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  // All stages clear together so the first post-reset cycle sees no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign sync = sync2_q;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
      assign edge_pulse = sync2_q & ~prev_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign edge_pulse = ~sync2_q & prev_q;
    end else begin : g_any
      assign edge_pulse = sync2_q ^ prev_q;
    end
  endgenerate

endmodule

// File: rtl/touch_pio_bidir.sv
// Avalon-MM bidirectional PIO with per-bit direction, open-drain option, edge capture and IRQ.
// Define TOUCH_PIO_BITSET_EN to add the atomic SET (addr 4) / CLR (addr 5) data_out ports.
module touch_pio_bidir
  import touch_pio_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_OUT  = '1,
  parameter logic [WIDTH-1:0] RESET_DIR  = '0,
  parameter int unsigned      EDGE_TYPE  = EDGE_ANY,
  parameter bit               OPEN_DRAIN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pad_out,
  output logic [WIDTH-1:0] pad_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] pad_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic             wr_en;

  touch_pio_sync_edge #(
    .WIDTH    (WIDTH),
    .EDGE_TYPE(EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset     (reset),
    .pad_in    (pad_in),
    .sync      (pad_sync),
    .edge_pulse(edge_pulse)
  );

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_mask_d = irq_mask_q;
    cap_clr    = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_out_d = writedata;
        ADDR_DIR:      dir_d      = writedata;
        ADDR_IRQ_MASK: irq_mask_d = writedata;
        ADDR_EDGE_CAP: cap_clr    = writedata;
`ifdef TOUCH_PIO_BITSET_EN
        ADDR_SET:      data_out_d = data_out_q | writedata;
        ADDR_CLR:      data_out_d = data_out_q & ~writedata;
`endif
        default: ;
      endcase
    end
    // A new edge overrides a same-cycle write-1-to-clear.
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_pulse;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= RESET_OUT;
      dir_q      <= RESET_DIR;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = pad_sync;
      ADDR_DIR:      readdata = dir_q;
      ADDR_IRQ_MASK: readdata = irq_mask_q;
      ADDR_EDGE_CAP: readdata = edge_cap_q;
      default:       readdata = '0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

  generate
    if (OPEN_DRAIN) begin : g_open_drain
      assign pad_oe  = dir_q & ~data_out_q;
      assign pad_out = '0;
    end else begin : g_push_pull
      assign pad_oe  = dir_q;
      assign pad_out = data_out_q;
    end
  endgenerate

endmodule

// File: tb/tb_touch_pio_bidir.sv
// Self-checking bench: push-pull and open-drain instances against a register-level model.
module tb_touch_pio_bidir;

  logic       clk;
  logic       reset;
  logic [2:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] pad_in;
  logic [7:0] readdata, pad_out, pad_oe;
  logic       irq;
  logic [7:0] od_readdata, od_pad_out, od_pad_oe;
  logic       od_irq;

  int total;
  int bad;

  // Model state: architectural registers plus the last three pad samples (newest first).
  logic [7:0] m_out, m_dir, m_mask, m_cap;
  logic [7:0] hist[$];

  touch_pio_bidir #(.WIDTH(8), .OPEN_DRAIN(1'b0)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .pad_in    (pad_in),
    .pad_out   (pad_out),
    .pad_oe    (pad_oe),
    .irq       (irq)
  );

  touch_pio_bidir #(.WIDTH(8), .OPEN_DRAIN(1'b1)) dut_od (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (od_readdata),
    .pad_in    (pad_in),
    .pad_out   (od_pad_out),
    .pad_oe    (od_pad_oe),
    .irq       (od_irq)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return hist[1];
      3'd1:    return m_dir;
      3'd2:    return m_mask;
      3'd3:    return m_cap;
      default: return 8'h00;
    endcase
  endfunction

  // One clock: update the model from the inputs seen at the edge, then settle 1 time unit.
  task automatic cycle();
    logic [7:0] clr;
    @(posedge clk);
    if (reset) begin
      m_out  = 8'hFF;
      m_dir  = 8'h00;
      m_mask = 8'h00;
      m_cap  = 8'h00;
      hist   = '{8'h00, 8'h00, 8'h00};
    end else begin
      clr = 8'h00;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out  = writedata;
          3'd1: m_dir  = writedata;
          3'd2: m_mask = writedata;
          3'd3: clr    = writedata;
`ifdef TOUCH_PIO_BITSET_EN
          3'd4: m_out  = m_out | writedata;
          3'd5: m_out  = m_out & ~writedata;
`endif
          default: ;
        endcase
      end
      // Any change between the two older samples is an edge (EDGE_ANY).
      m_cap = (m_cap & ~clr) | (hist[1] ^ hist[2]);
      hist.push_front(pad_in);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    cycle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    total++;
    if (pad_out !== 8'hFF) begin
      bad++; $display("FAIL reset_pad_out got=%h exp=%h", pad_out, 8'hFF);
    end
    total++;
    if (pad_oe !== 8'h00) begin
      bad++; $display("FAIL reset_pad_oe got=%h exp=%h", pad_oe, 8'h00);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    total++;
    if (od_pad_oe !== 8'h00 || od_pad_out !== 8'h00) begin
      bad++; $display("FAIL reset_od got oe=%h out=%h exp 00/00", od_pad_oe, od_pad_out);
    end
    for (int a = 1; a <= 3; a++) begin
      address = 3'(a);
      #1;
      total++;
      if (readdata !== 8'h00) begin
        bad++; $display("FAIL reset_read addr=%0d got=%h exp=00", a, readdata);
      end
    end
  endtask

  task automatic test_dir_data();
    wr(3'd1, 8'h0F);
    wr(3'd0, 8'hA5);
    total++;
    if (pad_oe !== 8'h0F || pad_out !== 8'hA5) begin
      bad++; $display("FAIL dir_data got oe=%h out=%h exp 0f/a5", pad_oe, pad_out);
    end
    total++;
    if (od_pad_oe !== 8'h0A || od_pad_out !== 8'h00) begin
      bad++; $display("FAIL dir_data_od got oe=%h out=%h exp 0a/00", od_pad_oe, od_pad_out);
    end
    address = 3'd1;
    #1;
    total++;
    if (readdata !== 8'h0F) begin
      bad++; $display("FAIL dir_read got=%h exp=0f", readdata);
    end
  endtask

  task automatic test_open_drain();
    wr(3'd1, 8'h03);
    wr(3'd0, 8'h02);
    total++;
    if (od_pad_oe !== 8'h01 || od_pad_out !== 8'h00) begin
      bad++; $display("FAIL open_drain got oe=%h out=%h exp 01/00", od_pad_oe, od_pad_out);
    end
  endtask

  task automatic test_edge_irq();
    wr(3'd2, 8'h04);
    address = 3'd0;
    pad_in  = 8'h04;
    cycle();
    total++;
    if (readdata !== 8'h00) begin
      bad++; $display("FAIL sync_t1 got=%h exp=00", readdata);
    end
    cycle();
    total++;
    if (readdata !== 8'h04 || irq !== 1'b0) begin
      bad++; $display("FAIL sync_t2 got data=%h irq=%b exp 04/0", readdata, irq);
    end
    cycle();
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL irq_t3 got=%b exp=1", irq);
    end
    address = 3'd3;
    #1;
    total++;
    if (readdata !== 8'h04) begin
      bad++; $display("FAIL edge_cap_read got=%h exp=04", readdata);
    end
    wr(3'd3, 8'h04);
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL irq_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_set_wins();
    pad_in = 8'h00;
    cycle();
    cycle();
    wr(3'd3, 8'h04);
    total++;
    if (irq !== 1'b1) begin
      bad++; $display("FAIL set_wins_irq got=%b exp=1", irq);
    end
    address = 3'd3;
    #1;
    total++;
    if (readdata !== 8'h04) begin
      bad++; $display("FAIL set_wins_cap got=%h exp=04", readdata);
    end
    wr(3'd3, 8'h04);
    total++;
    if (irq !== 1'b0) begin
      bad++; $display("FAIL set_wins_clear got=%b exp=0", irq);
    end
  endtask

  task automatic test_bitset();
    logic [7:0] exp_set, exp_clr;
`ifdef TOUCH_PIO_BITSET_EN
    exp_set = 8'h81;
    exp_clr = 8'h80;
`else
    exp_set = 8'h00;
    exp_clr = 8'h00;
`endif
    wr(3'd0, 8'h00);
    wr(3'd4, 8'h81);
    total++;
    if (pad_out !== exp_set) begin
      bad++; $display("FAIL bitset_set got=%h exp=%h", pad_out, exp_set);
    end
    wr(3'd5, 8'h01);
    total++;
    if (pad_out !== exp_clr) begin
      bad++; $display("FAIL bitset_clr got=%h exp=%h", pad_out, exp_clr);
    end
    for (int a = 4; a <= 7; a++) begin
      address = 3'(a);
      #1;
      total++;
      if (readdata !== 8'h00) begin
        bad++; $display("FAIL high_addr_read addr=%0d got=%h exp=00", a, readdata);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e_rd, e_oe, e_out, e_ood;
    logic       e_irq;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 3'($urandom_range(0, 7));
      writedata  = 8'($urandom);
      if ($urandom_range(0, 2) == 0) pad_in = pad_in ^ 8'($urandom);
      cycle();
      e_rd  = m_read(address);
      e_irq = |(m_cap & m_mask);
      e_oe  = m_dir;
      e_out = m_out;
      e_ood = m_dir & ~m_out;
      total++;
      if (readdata !== e_rd || irq !== e_irq || pad_oe !== e_oe || pad_out !== e_out) begin
        bad++;
        $display("FAIL random_pp i=%0d got rd=%h irq=%b oe=%h out=%h exp rd=%h irq=%b oe=%h out=%h",
                 i, readdata, irq, pad_oe, pad_out, e_rd, e_irq, e_oe, e_out);
      end
      total++;
      if (od_readdata !== e_rd || od_irq !== e_irq || od_pad_oe !== e_ood || od_pad_out !== 8'h00)
      begin
        bad++;
        $display("FAIL random_od i=%0d got rd=%h irq=%b oe=%h out=%h exp rd=%h irq=%b oe=%h out=00",
                 i, od_readdata, od_irq, od_pad_oe, od_pad_out, e_rd, e_irq, e_ood);
      end
    end
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 8'h00;
    pad_in     = 8'h00;
    total      = 0;
    bad        = 0;
    hist       = '{8'h00, 8'h00, 8'h00};
    m_out      = 8'hFF;
    m_dir      = 8'h00;
    m_mask     = 8'h00;
    m_cap      = 8'h00;
    #1;
    test_reset();
    test_dir_data();
    test_open_drain();
    test_edge_irq();
    test_set_wins();
    test_bitset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
